// File: rtl/ads1672_pkg.sv
// Shared constants and FSM state type for the ADS1672 serial capture controller.
package ads1672_pkg;

    localparam int unsigned DATA_WIDTH       = 24;
    localparam int unsigned SCLK_DIV_DEF     = 4;
    localparam int unsigned DRDY_TIMEOUT_DEF = 65535;

    typedef enum logic [2:0] {
        StIdle,
        StStartup,
        StWaitDrdy,
        StFrame,
        StShift,
        StEmit,
        StStop
    } state_e;

endpackage

// File: rtl/ads1672_sclk_gen.sv
// Serial clock divider: free-runs 0..SCLK_DIV-1 while enabled, parks at 0 otherwise.
module ads1672_sclk_gen #(
    parameter int unsigned SCLK_DIV = ads1672_pkg::SCLK_DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic clkx_o,
    output logic wrap_o
);

    localparam int unsigned CntW = $clog2(SCLK_DIV);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clkx_q;

    assign wrap_o = en_i && (cnt_q == CntW'(SCLK_DIV - 1));

    always_comb begin
        cnt_d = '0;
        if (en_i && !wrap_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // clkx is registered from the next count so it stays aligned with cnt_q and glitch-free.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            clkx_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clkx_q <= (cnt_d >= CntW'(SCLK_DIV / 2));
        end
    end

    assign clkx_o = clkx_q;

endmodule

// File: rtl/ads1672_ctrl.sv
// ADS1672 burst controller: waits for DRDY, frames and shifts in one word per conversion.
module ads1672_ctrl #(
    parameter int unsigned DATA_WIDTH   = ads1672_pkg::DATA_WIDTH,
    parameter int unsigned SCLK_DIV     = ads1672_pkg::SCLK_DIV_DEF,
    parameter int unsigned DRDY_TIMEOUT = ads1672_pkg::DRDY_TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  measure_i,
    input  logic [15:0]           num_samples_i,
    input  logic                  abort_i,
    output logic                  clkx_o,
    output logic                  fsx_o,
    input  logic                  drr_i,
    input  logic                  drdy_n_i,
    output logic                  start_o,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  data_valid_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    import ads1672_pkg::*;

    localparam int unsigned BitW = $clog2(DATA_WIDTH);
    localparam int unsigned TmoW = $clog2(DRDY_TIMEOUT + 1);

    state_e                state_q;
    logic [2:0]            sync_q;
    logic [TmoW-1:0]       tmo_q;
    logic [BitW-1:0]       bit_q;
    logic [15:0]           rem_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  fsx_q;
    logic                  start_q;
    logic                  timeout_q;
    logic                  sclk_en;
    logic                  sclk_wrap;
    logic                  drdy_evt;

    assign sclk_en  = (state_q == StFrame) || (state_q == StShift);
    assign drdy_evt = sync_q[2] & ~sync_q[1];

    ads1672_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (sclk_en),
        .clkx_o (clkx_o),
        .wrap_o (sclk_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            sync_q    <= 3'b111;
            tmo_q     <= '0;
            bit_q     <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fsx_q     <= 1'b0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], drdy_n_i};
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (measure_i) begin
                        state_q   <= StStartup;
                        rem_q     <= (num_samples_i == 16'd0) ? 16'd1 : num_samples_i;
                        timeout_q <= 1'b0;
                        start_q   <= 1'b1;
                        tmo_q     <= '0;
                    end
                end
                // tmo_q doubles as the two-cycle startup counter.
                StStartup: begin
                    if (tmo_q == TmoW'(1)) begin
                        state_q <= StWaitDrdy;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StWaitDrdy: begin
                    if (drdy_evt) begin
                        state_q <= StFrame;
                        fsx_q   <= 1'b1;
                    end else if (tmo_q == TmoW'(DRDY_TIMEOUT - 1)) begin
                        state_q   <= StStop;
                        timeout_q <= 1'b1;
                        start_q   <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StFrame: begin
                    if (sclk_wrap) begin
                        state_q <= StShift;
                        fsx_q   <= 1'b0;
                        bit_q   <= '0;
                    end
                end
                StShift: begin
                    if (sclk_wrap) begin
                        shift_q <= {shift_q[DATA_WIDTH-2:0], drr_i};
                        if (bit_q == BitW'(DATA_WIDTH - 1)) begin
                            state_q <= StEmit;
                            bit_q   <= '0;
                        end else begin
                            bit_q <= bit_q + BitW'(1);
                        end
                    end
                end
                StEmit: begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                    rem_q   <= rem_q - 16'd1;
                    if ((rem_q == 16'd1) || abort_i) begin
                        state_q <= StStop;
                        start_q <= 1'b0;
                    end else begin
                        state_q <= StWaitDrdy;
                        tmo_q   <= '0;
                    end
                end
                StStop: begin
                    state_q <= StIdle;
                    start_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fsx_o        = fsx_q;
    assign start_o      = start_q;
    assign data_out_o   = data_q;
    assign data_valid_o = valid_q;
    assign busy_o       = (state_q != StIdle);
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_ads1672_ctrl.sv
// Directed bench for ads1672_ctrl with a simple ADC serial-output model.
module tb_ads1672_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        measure = 1'b0;
    logic [15:0] num_samples = 16'd0;
    logic        abort = 1'b0;
    logic        clkx;
    logic        fsx;
    logic        drr = 1'b0;
    logic        drdy_n = 1'b1;
    logic        start;
    logic [23:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        timeout;

    int passed = 0;
    int total = 0;
    int vcount = 0;

    logic [23:0] words [0:31];
    int          widx = 0;
    int          bidx = -1;
    logic [23:0] cur_word = 24'd0;
    logic        prev_fsx = 1'b0;
    logic        prev_clkx = 1'b0;

    ads1672_ctrl #(
        .DATA_WIDTH   (24),
        .SCLK_DIV     (4),
        .DRDY_TIMEOUT (100)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .measure_i     (measure),
        .num_samples_i (num_samples),
        .abort_i       (abort),
        .clkx_o        (clkx),
        .fsx_o         (fsx),
        .drr_i         (drr),
        .drdy_n_i      (drdy_n),
        .start_o       (start),
        .data_out_o    (data_out),
        .data_valid_o  (data_valid),
        .busy_o        (busy),
        .timeout_o     (timeout)
    );

    always #5 clk = ~clk;

    // ADC model: loads the next word on frame sync, drives one bit per clkx rise after the frame.
    always @(negedge clk) begin
        if (data_valid === 1'b1) vcount++;
        if (fsx && !prev_fsx) begin
            cur_word = words[widx];
            widx = widx + 1;
            bidx = 23;
        end else if (clkx && !prev_clkx && !fsx && bidx >= 0) begin
            drr = cur_word[bidx];
            bidx = bidx - 1;
        end
        prev_fsx = fsx;
        prev_clkx = clkx;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_measure(input logic [15:0] n);
        measure = 1'b1;
        num_samples = n;
        tick();
        measure = 1'b0;
        tick();
        tick();
    endtask

    // Drops drdy_n, then waits for the word; latency counted from the drdy_n drive.
    task automatic get_word(input logic [23:0] exp, input int abort_at, input int meas_at,
                            input string tag);
        int n;
        int fsx_n;
        int rise_n;
        logic prev_c;
        logic got;
        n = 0; fsx_n = 0; rise_n = 0; prev_c = clkx; got = 1'b0;
        drdy_n = 1'b0;
        while (n < 400 && !got) begin
            tick();
            n++;
            if (n == 3) drdy_n = 1'b1;
            if (n == abort_at) abort = 1'b1;
            if (n == meas_at) begin
                measure = 1'b1;
                num_samples = 16'd7;
            end
            if (n == meas_at + 1) measure = 1'b0;
            if (fsx) fsx_n++;
            if (clkx && !prev_c) rise_n++;
            prev_c = clkx;
            if (data_valid === 1'b1) got = 1'b1;
        end
        total++;
        if (n !== 104) $display("FAIL %s latency: got %0d want 104", tag, n);
        else passed++;
        total++;
        if (data_out !== exp) $display("FAIL %s data_out: got %h want %h", tag, data_out, exp);
        else passed++;
        total++;
        if (fsx_n !== 4) $display("FAIL %s fsx_width: got %0d want 4", tag, fsx_n);
        else passed++;
        total++;
        if (rise_n !== 25) $display("FAIL %s clkx_rises: got %0d want 25", tag, rise_n);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({clkx, fsx, start, data_valid, busy, timeout} !== 6'b0)
            $display("FAIL reset ctrl: got %b want 000000",
                     {clkx, fsx, start, data_valid, busy, timeout});
        else passed++;
        total++;
        if (data_out !== 24'd0) $display("FAIL reset data_out: got %h want 000000", data_out);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int v0;
        v0 = vcount;
        words[widx] = 24'hCACF0C;
        pulse_measure(16'd1);
        total++;
        if ({start, busy} !== 2'b11) $display("FAIL single start_busy: got %b want 11",
                                             {start, busy});
        else passed++;
        get_word(24'hCACF0C, 0, 0, "single");
        total++;
        if ({start, busy} !== 2'b01) $display("FAIL single stop: got %b want 01", {start, busy});
        else passed++;
        tick();
        total++;
        if ({busy, data_valid} !== 2'b00) $display("FAIL single idle: got %b want 00",
                                                  {busy, data_valid});
        else passed++;
        total++;
        if (data_out !== 24'hCACF0C) $display("FAIL single hold: got %h want cacf0c", data_out);
        else passed++;
        total++;
        if (vcount - v0 !== 1) $display("FAIL single strobes: got %0d want 1", vcount - v0);
        else passed++;
    endtask

    task automatic test_burst();
        int v0;
        v0 = vcount;
        words[widx]     = 24'h000001;
        words[widx + 1] = 24'h7FFFFF;
        words[widx + 2] = 24'h800000;
        pulse_measure(16'd3);
        get_word(24'h000001, 0, 0, "burst0");
        total++;
        if (start !== 1'b1) $display("FAIL burst start0: got %b want 1", start);
        else passed++;
        get_word(24'h7FFFFF, 0, 0, "burst1");
        total++;
        if (start !== 1'b1) $display("FAIL burst start1: got %b want 1", start);
        else passed++;
        get_word(24'h800000, 0, 0, "burst2");
        total++;
        if (start !== 1'b0) $display("FAIL burst start2: got %b want 0", start);
        else passed++;
        tick();
        total++;
        if (vcount - v0 !== 3) $display("FAIL burst strobes: got %0d want 3", vcount - v0);
        else passed++;
    endtask

    task automatic test_timeout();
        int v0;
        v0 = vcount;
        measure = 1'b1;
        num_samples = 16'd1;
        tick();
        measure = 1'b0;
        for (int i = 1; i <= 102; i++) begin
            tick();
            if (i == 101) begin
                total++;
                if (timeout !== 1'b0) $display("FAIL timeout early: got %b want 0", timeout);
                else passed++;
            end
        end
        total++;
        if ({timeout, busy, start} !== 3'b110)
            $display("FAIL timeout set: got %b want 110", {timeout, busy, start});
        else passed++;
        tick();
        total++;
        if ({timeout, busy} !== 2'b10) $display("FAIL timeout idle: got %b want 10",
                                               {timeout, busy});
        else passed++;
        total++;
        if (vcount - v0 !== 0) $display("FAIL timeout strobes: got %0d want 0", vcount - v0);
        else passed++;
        words[widx] = 24'h5A5A5A;
        pulse_measure(16'd0);
        total++;
        if (timeout !== 1'b0) $display("FAIL timeout clear: got %b want 0", timeout);
        else passed++;
        get_word(24'h5A5A5A, 0, 0, "after_timeout");
        tick();
    endtask

    task automatic test_abort();
        int v0;
        v0 = vcount;
        words[widx]     = 24'h123456;
        words[widx + 1] = 24'hABCDEF;
        words[widx + 2] = 24'hFFFFFF;
        pulse_measure(16'd5);
        get_word(24'h123456, 0, 0, "abort0");
        get_word(24'hABCDEF, 50, 0, "abort1");
        total++;
        if (start !== 1'b0) $display("FAIL abort stop: got %b want 0", start);
        else passed++;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL abort idle: got %b want 0", busy);
        else passed++;
        repeat (20) tick();
        total++;
        if (vcount - v0 !== 2) $display("FAIL abort strobes: got %0d want 2", vcount - v0);
        else passed++;
    endtask

    task automatic test_measure_busy();
        int v0;
        v0 = vcount;
        words[widx]     = 24'h0F0F0F;
        words[widx + 1] = 24'hF0F0F0;
        pulse_measure(16'd2);
        get_word(24'h0F0F0F, 0, 50, "mbusy0");
        get_word(24'hF0F0F0, 0, 0, "mbusy1");
        total++;
        if (start !== 1'b0) $display("FAIL mbusy stop: got %b want 0", start);
        else passed++;
        repeat (10) tick();
        total++;
        if (busy !== 1'b0) $display("FAIL mbusy idle: got %b want 0", busy);
        else passed++;
        total++;
        if (vcount - v0 !== 2) $display("FAIL mbusy strobes: got %0d want 2", vcount - v0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int v0;
        v0 = vcount;
        words[widx] = 24'h3C3C3C;
        pulse_measure(16'd4);
        drdy_n = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (n == 3) drdy_n = 1'b1;
        end
        rst_n = 1'b0;
        tick();
        total++;
        if ({clkx, fsx, start, data_valid, busy, timeout} !== 6'b0)
            $display("FAIL rstmid ctrl: got %b want 000000",
                     {clkx, fsx, start, data_valid, busy, timeout});
        else passed++;
        total++;
        if (data_out !== 24'd0) $display("FAIL rstmid data_out: got %h want 000000", data_out);
        else passed++;
        rst_n = 1'b1;
        repeat (150) tick();
        total++;
        if ({busy, vcount - v0} !== {1'b0, 32'd0})
            $display("FAIL rstmid after: got busy %b strobes %0d want 0 0", busy, vcount - v0);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) words[i] = 24'd0;
        test_reset();
        test_single();
        test_burst();
        test_timeout();
        test_abort();
        test_measure_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ads1672_ctrl.md
ADS1672_CTRL -- requirements
Module: ads1672_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 24: ADC conversion word width in bits.
REQ-002 Parameter SCLK_DIV, default 4: serial clock period in clk cycles; even, >= 2.
REQ-003 Parameter DRDY_TIMEOUT, default 65535: clk cycles to wait for drdy_n before flagging timeout.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 measure  input  1  one-cycle pulse that starts a burst; ignored while busy.
REQ-007 num_samples  input  16  conversions per burst; latched on accepted measure; 0 is treated as 1.
REQ-008 abort  input  1  level; terminates the burst at the next word boundary.
REQ-009 clkx  output  1  serial clock to ADC; idle low.
REQ-010 fsx  output  1  frame sync to ADC, active high.
REQ-011 drr  input  1  serial data from ADC, MSB first.
REQ-012 drdy_n  input  1  asynchronous data-ready from ADC, active low.
REQ-013 start  output  1  ADC START pin; high while a conversion burst is active.
REQ-014 data_out  output  DATA_WIDTH  last received word; held until the next word.
REQ-015 data_valid  output  1  one-cycle strobe; data_out is new this cycle.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout  output  1  sticky error flag; cleared by the next accepted measure.

Function
REQ-018 States: IDLE, STARTUP, WAIT_DRDY, FRAME, SHIFT, EMIT, STOP.
REQ-019 IDLE -> STARTUP on measure; latch num_samples; clear timeout; start=1 on the next cycle.
REQ-020 STARTUP lasts exactly 2 clk cycles, then WAIT_DRDY.
REQ-021 drdy_n passes through a 2-flop synchronizer; the event is a falling edge of the synchronized signal.
REQ-022 WAIT_DRDY -> FRAME on a drdy event; the timeout counter resets on entry.
REQ-023 If the timeout counter reaches DRDY_TIMEOUT in WAIT_DRDY: set timeout=1 and go to STOP.
REQ-024 Divider counter runs 0..SCLK_DIV-1 only in FRAME and SHIFT; clkx=1 when count >= SCLK_DIV/2, else 0.
REQ-025 FRAME: fsx=1 for exactly one clkx period (SCLK_DIV clk cycles), then SHIFT; fsx=0 in all other states.
REQ-026 SHIFT: sample drr into the shift register MSB first on the clk cycle where the counter wraps from SCLK_DIV-1 to 0 (clkx falling edge).
REQ-027 After DATA_WIDTH samples go to EMIT; the divider resets to 0, so clkx ends low.
REQ-028 EMIT, one cycle: data_out <= shift register; data_valid=1; decrement the remaining count.
REQ-029 EMIT -> STOP if the remaining count reaches 0 or abort=1; otherwise -> WAIT_DRDY.
REQ-030 abort in any other non-IDLE state takes effect only at EMIT or the timeout; an in-flight word always completes.
REQ-031 STOP, one cycle: start=0, then IDLE.
REQ-032 measure arriving while busy is dropped, with no queuing.
REQ-033 A drdy event outside WAIT_DRDY is ignored; the missed conversion is not flagged.
REQ-034 Latency, drdy event to data_valid: SCLK_DIV*(DATA_WIDTH+1)+2 clk cycles after the synchronized edge.

Reset
REQ-035 On rst_n=0 at a clk edge: state=IDLE, clkx=0, fsx=0, start=0, data_out=0, data_valid=0, busy=0, timeout=0, all counters and the synchronizer reset to the idle value (drdy_n sync = 1).
REQ-036 Reset mid-burst aborts immediately, with no final data_valid; start drops in the cycle after reset is sampled.

Structure
REQ-037 Package ads1672_pkg holds DATA_WIDTH, the state enum typedef, and the default SCLK_DIV and DRDY_TIMEOUT constants.
REQ-038 One sub-module, ads1672_sclk_gen: divider counter, clkx output, wrap strobe and enable input.
REQ-039 The synchronizer and edge detect stay inline.

Verification
REQ-040 Single conversion, num_samples=1, ADC model drives 0xCACF0C -> one data_valid with data_out=0xCACF0C; start low 1 cycle after EMIT; busy low after STOP.
REQ-041 Burst, num_samples=3, model words 0x000001, 0x7FFFFF, 0x800000 -> three data_valid strobes in order with those values; start held high across the burst.
REQ-042 drdy_n never asserted, DRDY_TIMEOUT=100 -> timeout=1 about 102 cycles after STARTUP; no data_valid; state returns to IDLE; the next measure clears timeout.
REQ-043 abort raised mid-SHIFT of word 2 of 5 -> word 2 is emitted, then STOP; exactly 2 data_valid strobes.
REQ-044 measure pulsed during SHIFT -> ignored; num_samples is not re-latched.
REQ-045 rst_n low mid-SHIFT -> all outputs reach reset values next cycle; no data_valid.
